pingpong_frame_writer: RTL and testbench
========================================

# pingpong_frame_writer

Upstream fill stage for the 32x256 ping-pong frame buffer. It takes the 16-bit microphone sample stream, aligned to start-of-frame markers, and packs sample pairs into 32-bit words. It writes those words sequentially to buffer addresses 0..255, then holds `writeDone` until the buffer swap completes. Each frame carries 512 samples in 256 words.

## Interface
Parameters: none (geometry fixed at 32-bit x 256 words).

- `clk` in 1: system clock, rising edge.
- `reset_n` in 1: asynchronous active-low reset.
- `in_valid` in 1: sample strobe, one sample per cycle when high.
- `in_data` in 16: signed mic sample.
- `in_sof` in 1: qualifies `in_valid`; marks the first sample of a frame.
- `goodToGo` in 1: from the ping-pong buffer; low for exactly one cycle during a swap.
- `clear_err` in 1: clears the sticky error flags.
- `w_addr` out 8: buffer write address.
- `w_data` out 32: packed word; first sample in [15:0], second in [31:16].
- `wren` out 1: write strobe, one cycle per word.
- `writeDone` out 1: high while the frame is complete and waiting for the swap.
- `overflow` out 1: sticky; a sample was dropped while the frame was full.
- `sync_err` out 1: sticky; `in_sof` arrived mid-frame.
- `frame_count` out 16: number of frames handed off, wraps.

All outputs are registered.

## Operation
- States:
  - SYNC: discard samples until the first one with `in_sof`.
  - FILL: pack samples and write words.
  - FULL: hold `writeDone=1` and wait for the swap.
- Reset values: all outputs 0, state SYNC, half-word register empty, internal word address 0.
- SYNC:
  - Accepts a sample only when `in_valid & in_sof`.
  - The accepted sample goes to the low-half register; state moves to FILL with word address 0.
  - Samples without `in_sof` are dropped silently; no flag is set.
- FILL, low half empty: a sample is latched as the low half.
- FILL, low half full: a sample completes the word.
  - Next cycle: `wren=1`, `w_addr` = word address, `w_data` = {sample, low}.
  - Word address then increments.
- FILL, end of frame: the write of word 255 moves the state to FULL, and `writeDone=1` from the following cycle.
- `in_sof` during FILL:
  - At the very first sample of word 0 it is legal; this case cannot occur after SYNC anyway.
  - Any other position: `sync_err` set; the current partial word is discarded.
  - This sample becomes the low half of word 0 and the word address resets to 0. The frame restarts and stale words are overwritten.
- FULL:
  - Every `in_valid` sample is dropped and sets `overflow`.
  - When `goodToGo==0` is sampled: next cycle `writeDone=0`, `frame_count` increments, state SYNC.
  - A sample arriving in that same cycle is dropped and sets `overflow`, even if it carries `in_sof`.
- `goodToGo` is ignored in SYNC and FILL. A low level there, such as the buffer's own post-reset swap cycle, has no effect.
- Sticky flags: `clear_err` clears `overflow` and `sync_err`. If a set event and a clear occur in the same cycle, set wins.
- `frame_count` wraps 0xFFFF -> 0x0000.
- `w_addr` and `w_data` hold their last values when `wren=0`.

## Timing
- Latency: the second sample of a pair at edge N gives `wren` high during cycle N+1.
- Peak rate: at most one `wren` every 2 accepted samples; back-to-back `in_valid` therefore gives `wren` every other cycle.
- Minimum frame fill time: 512 cycles from the first accepted sample to the last `wren`.
- `writeDone` rises the cycle after the word-255 `wren`. It stays high until the cycle after `goodToGo` is sampled low, with no glitch in between.
- The swap handshake needs the buffer's `readDone` as well. `writeDone` is held indefinitely; there is no timeout.
- Reset asserted mid-frame:
  - Immediate return to reset values: `wren` and `writeDone` drop asynchronously.
  - After reset release, the block waits in SYNC for a new `in_sof`.

## Test plan
- Reset then a continuous stream: `in_sof` on sample 0, samples 0x0000..0x01FF -> 256 `wren`s every other cycle. Word k = {2k+1, 2k}, word 0 = 0x00010000. `writeDone` rises 1 cycle after the `w_addr`=255 write.
- Full frame, then pulse `goodToGo` low for 1 cycle after 10 cycles -> `writeDone` falls next cycle and `frame_count`=1. The next frame starts only at the next `in_sof` and rewrites addr 0.
- Stream continues during FULL for 5 samples -> no `wren`, `overflow`=1. `clear_err` then clears it; `clear_err` coincident with a new drop leaves `overflow`=1.
- `in_sof` on sample 101 of a frame -> `sync_err`=1. Next `wren` at `w_addr`=0 with the low half = the sof sample; 256 more words are needed before `writeDone`.
- `goodToGo` low during FILL at word 40 -> no effect: `writeDone` stays 0 and `frame_count` is unchanged.
- `reset_n` low at word 128 -> `wren`/`writeDone` 0 immediately. After release, samples without `in_sof` produce no writes.

Source files
------------

// File: rtl/pingpong_frame_writer_if.sv
// Bundle between the frame writer and its neighbours: the sample stream in,
// the swap handshake, and the word-write port into the ping-pong buffer.
interface pingpong_frame_writer_if;
   // Sample stream
   logic        in_valid;
   logic [15:0] in_data;
   logic        in_sof;
   // Swap handshake and error control
   logic        goodToGo;
   logic        clear_err;
   // Buffer write port and status
   logic [7:0]  w_addr;
   logic [31:0] w_data;
   logic        wren;
   logic        writeDone;
   logic        overflow;
   logic        sync_err;
   logic [15:0] frame_count;

   // Writer side: consumes the stream, drives the buffer write port
   modport master (
      input  in_valid, in_data, in_sof, goodToGo, clear_err,
      output w_addr, w_data, wren, writeDone, overflow, sync_err, frame_count
   );

   // Environment side: supplies the stream, observes the write port
   modport slave (
      output in_valid, in_data, in_sof, goodToGo, clear_err,
      input  w_addr, w_data, wren, writeDone, overflow, sync_err, frame_count
   );
endinterface

// File: rtl/pingpong_frame_writer.sv
// Fill stage for the 32x256 ping-pong frame buffer. Aligns the 16-bit mic stream
// to start-of-frame, packs sample pairs into 32-bit words written to addresses
// 0..255, then holds writeDone until the buffer signals the swap.
module pingpong_frame_writer (
   input logic                    clk,
   input logic                    reset_n,
   pingpong_frame_writer_if.master bus
);

   typedef enum logic [1:0] {
      StSync,
      StFill,
      StFull
   } state_e;

   state_e      state_q, state_d;
   logic [15:0] low_q, low_d;            // first sample of the word being built
   logic        low_full_q, low_full_d;  // low half holds a sample
   logic [7:0]  addr_q, addr_d;          // word address of the word being built
   logic [7:0]  w_addr_q, w_addr_d;
   logic [31:0] w_data_q, w_data_d;
   logic        wren_q, wren_d;
   logic        write_done_q, write_done_d;
   logic        overflow_q, overflow_d;
   logic        sync_err_q, sync_err_d;
   logic [15:0] frame_count_q, frame_count_d;
   logic        ovf_set;
   logic        sync_set;

   // State and registered outputs; reset drops wren/writeDone immediately.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= StSync;
         low_q         <= 16'h0000;
         low_full_q    <= 1'b0;
         addr_q        <= 8'h00;
         w_addr_q      <= 8'h00;
         w_data_q      <= 32'h0000_0000;
         wren_q        <= 1'b0;
         write_done_q  <= 1'b0;
         overflow_q    <= 1'b0;
         sync_err_q    <= 1'b0;
         frame_count_q <= 16'h0000;
      end else begin
         state_q       <= state_d;
         low_q         <= low_d;
         low_full_q    <= low_full_d;
         addr_q        <= addr_d;
         w_addr_q      <= w_addr_d;
         w_data_q      <= w_data_d;
         wren_q        <= wren_d;
         write_done_q  <= write_done_d;
         overflow_q    <= overflow_d;
         sync_err_q    <= sync_err_d;
         frame_count_q <= frame_count_d;
      end
   end

   // Next-state: frame alignment, pair packing, full hold and sticky flags.
   always_comb begin
      state_d       = state_q;
      low_d         = low_q;
      low_full_d    = low_full_q;
      addr_d        = addr_q;
      w_addr_d      = w_addr_q;   // write port holds its last values between strobes
      w_data_d      = w_data_q;
      wren_d        = 1'b0;
      write_done_d  = 1'b0;
      frame_count_d = frame_count_q;
      ovf_set       = 1'b0;
      sync_set      = 1'b0;

      unique case (state_q)
         StSync: begin
            // Anything before the first marked sample is dropped silently.
            if (bus.in_valid && bus.in_sof) begin
               low_d      = bus.in_data;
               low_full_d = 1'b1;
               addr_d     = 8'h00;
               state_d    = StFill;
            end
         end

         StFill: begin
            if (bus.in_valid) begin
               if (bus.in_sof && (low_full_q || (addr_q != 8'h00))) begin
                  // Misplaced marker: drop the partial word and restart at word 0.
                  sync_set   = 1'b1;
                  low_d      = bus.in_data;
                  low_full_d = 1'b1;
                  addr_d     = 8'h00;
               end else if (!low_full_q) begin
                  low_d      = bus.in_data;
                  low_full_d = 1'b1;
               end else begin
                  wren_d     = 1'b1;
                  w_addr_d   = addr_q;
                  w_data_d   = {bus.in_data, low_q};
                  low_full_d = 1'b0;
                  addr_d     = addr_q + 8'd1;
                  if (addr_q == 8'hFF) begin
                     state_d = StFull;
                  end
               end
            end
         end

         StFull: begin
            write_done_d = 1'b1;
            // No room until the swap; every sample here is lost, sof or not.
            if (bus.in_valid) begin
               ovf_set = 1'b1;
            end
            if (!bus.goodToGo) begin
               write_done_d  = 1'b0;
               frame_count_d = frame_count_q + 16'd1;
               state_d       = StSync;
            end
         end

         default: begin
            state_d = StSync;
         end
      endcase

      // A set in the same cycle as a clear wins.
      overflow_d = ovf_set | (overflow_q & ~bus.clear_err);
      sync_err_d = sync_set | (sync_err_q & ~bus.clear_err);
   end

   assign bus.w_addr      = w_addr_q;
   assign bus.w_data      = w_data_q;
   assign bus.wren        = wren_q;
   assign bus.writeDone   = write_done_q;
   assign bus.overflow    = overflow_q;
   assign bus.sync_err    = sync_err_q;
   assign bus.frame_count = frame_count_q;

endmodule

// File: tb/tb_pingpong_frame_writer.sv
// Directed bench for pingpong_frame_writer: full frames, swap, overflow,
// mid-frame sof, ignored goodToGo during fill, and reset mid-frame.
module tb_pingpong_frame_writer;

   logic clk;
   logic reset_n;
   int   checks;
   int   errors;

   pingpong_frame_writer_if bus ();

   pingpong_frame_writer dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; outputs are then stable and inputs may change.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic v, input logic [15:0] d, input logic s);
      bus.in_valid = v;
      bus.in_data  = d;
      bus.in_sof   = s;
      tick();
   endtask

   initial begin
      logic [31:0] exp_word;
      checks        = 0;
      errors        = 0;
      reset_n       = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = 16'h0000;
      bus.in_sof    = 1'b0;
      bus.goodToGo  = 1'b1;
      bus.clear_err = 1'b0;

      // Reset state
      tick();
      tick();
      check("rst_wren", {31'd0, bus.wren}, 32'd0);
      check("rst_done", {31'd0, bus.writeDone}, 32'd0);
      check("rst_ovf", {31'd0, bus.overflow}, 32'd0);
      check("rst_serr", {31'd0, bus.sync_err}, 32'd0);
      check("rst_fcnt", {16'd0, bus.frame_count}, 32'd0);
      check("rst_addr", {24'd0, bus.w_addr}, 32'd0);
      check("rst_data", bus.w_data, 32'd0);
      reset_n = 1'b1;
      tick();

      // SYNC drops unmarked samples silently
      for (int i = 0; i < 4; i++) begin
         send(1'b1, 16'hAAAA, 1'b0);
         check("sync_drop_wren", {31'd0, bus.wren}, 32'd0);
      end
      check("sync_drop_serr", {31'd0, bus.sync_err}, 32'd0);

      // Frame 1: samples 0..511, word k = {2k+1, 2k}
      for (int i = 0; i < 512; i++) begin
         send(1'b1, 16'(i), i == 0);
         if (i % 2 == 1) begin
            exp_word = {16'(i), 16'(i - 1)};
            check("f1_wren", {31'd0, bus.wren}, 32'd1);
            check("f1_addr", {24'd0, bus.w_addr}, 32'(i / 2));
            check("f1_data", bus.w_data, exp_word);
         end else begin
            check("f1_wren_idle", {31'd0, bus.wren}, 32'd0);
         end
         check("f1_done_low", {31'd0, bus.writeDone}, 32'd0);
      end
      send(1'b0, 16'h0000, 1'b0);
      check("f1_done_rise", {31'd0, bus.writeDone}, 32'd1);
      check("f1_wren_off", {31'd0, bus.wren}, 32'd0);
      check("f1_addr_hold", {24'd0, bus.w_addr}, 32'd255);
      check("f1_data_hold", bus.w_data, 32'h01FF_01FE);
      check("f1_ovf_clean", {31'd0, bus.overflow}, 32'd0);

      // Stream continues during FULL: dropped, overflow set
      for (int i = 0; i < 5; i++) begin
         send(1'b1, 16'h5555, 1'b0);
         check("full_wren", {31'd0, bus.wren}, 32'd0);
         check("full_done", {31'd0, bus.writeDone}, 32'd1);
      end
      check("full_ovf", {31'd0, bus.overflow}, 32'd1);
      bus.clear_err = 1'b1;
      send(1'b0, 16'h0000, 1'b0);
      check("ovf_clear", {31'd0, bus.overflow}, 32'd0);
      send(1'b1, 16'h1234, 1'b1);
      check("ovf_set_wins", {31'd0, bus.overflow}, 32'd1);
      send(1'b0, 16'h0000, 1'b0);
      check("ovf_clear2", {31'd0, bus.overflow}, 32'd0);
      bus.clear_err = 1'b0;

      // Held without a swap
      for (int i = 0; i < 10; i++) begin
         send(1'b0, 16'h0000, 1'b0);
         check("hold_done", {31'd0, bus.writeDone}, 32'd1);
      end
      check("hold_fcnt", {16'd0, bus.frame_count}, 32'd0);
      bus.goodToGo = 1'b0;
      send(1'b0, 16'h0000, 1'b0);
      bus.goodToGo = 1'b1;
      check("swap_done", {31'd0, bus.writeDone}, 32'd0);
      check("swap_fcnt", {16'd0, bus.frame_count}, 32'd1);

      // Back in SYNC: unmarked samples give no writes
      for (int i = 0; i < 3; i++) begin
         send(1'b1, 16'h7777, 1'b0);
         check("sync2_wren", {31'd0, bus.wren}, 32'd0);
      end

      // Frame 2: 101 samples, then sof on sample 101 restarts the frame
      for (int j = 0; j < 101; j++) begin
         send(1'b1, 16'h1000 + 16'(j), j == 0);
         check("f2a_wren", {31'd0, bus.wren}, 32'(j % 2));
         if (j == 1) begin
            check("f2a_addr0", {24'd0, bus.w_addr}, 32'd0);
            check("f2a_data0", bus.w_data, 32'h1001_1000);
         end
      end
      for (int k = 0; k < 512; k++) begin
         bus.goodToGo = (k == 81) ? 1'b0 : 1'b1;
         send(1'b1, 16'h2000 + 16'(k), k == 0);
         if (k == 0) begin
            check("serr_set", {31'd0, bus.sync_err}, 32'd1);
            check("serr_wren", {31'd0, bus.wren}, 32'd0);
         end
         if (k % 2 == 1) begin
            exp_word = {16'h2000 + 16'(k), 16'h2000 + 16'(k - 1)};
            check("f2_wren", {31'd0, bus.wren}, 32'd1);
            check("f2_addr", {24'd0, bus.w_addr}, 32'(k / 2));
            check("f2_data", bus.w_data, exp_word);
         end
         if (k == 81) begin
            check("g2g_fill_done", {31'd0, bus.writeDone}, 32'd0);
            check("g2g_fill_fcnt", {16'd0, bus.frame_count}, 32'd1);
         end
         check("f2_done_low", {31'd0, bus.writeDone}, 32'd0);
      end
      bus.goodToGo = 1'b1;
      send(1'b0, 16'h0000, 1'b0);
      check("f2_done_rise", {31'd0, bus.writeDone}, 32'd1);
      check("f2_serr_sticky", {31'd0, bus.sync_err}, 32'd1);
      bus.clear_err = 1'b1;
      send(1'b0, 16'h0000, 1'b0);
      bus.clear_err = 1'b0;
      check("serr_clear", {31'd0, bus.sync_err}, 32'd0);
      bus.goodToGo = 1'b0;
      send(1'b0, 16'h0000, 1'b0);
      bus.goodToGo = 1'b1;
      check("swap2_done", {31'd0, bus.writeDone}, 32'd0);
      check("swap2_fcnt", {16'd0, bus.frame_count}, 32'd2);

      // Frame 3: reset asserted right after the word-128 write
      for (int m = 0; m < 258; m++) begin
         send(1'b1, 16'h3000 + 16'(m), m == 0);
      end
      check("f3_wren128", {31'd0, bus.wren}, 32'd1);
      check("f3_addr128", {24'd0, bus.w_addr}, 32'd128);
      reset_n = 1'b0;
      #1;
      check("async_wren", {31'd0, bus.wren}, 32'd0);
      check("async_done", {31'd0, bus.writeDone}, 32'd0);
      check("async_fcnt", {16'd0, bus.frame_count}, 32'd0);
      tick();
      reset_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         send(1'b1, 16'h4000 + 16'(i), 1'b0);
         check("post_rst_wren", {31'd0, bus.wren}, 32'd0);
      end
      check("post_rst_addr", {24'd0, bus.w_addr}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
